// File: rtl/i2c_slave_ctrl.sv
// Transaction sequencer for a read-only I2C slave: walks address, ACK/NACK,
// byte transmit and master-ACK phases from decoder and SCL-edge strobes.
module i2c_slave_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       address_match,
    input  logic       rw_mode,
    input  logic       scl_rise,
    input  logic       scl_fall,
    input  logic       sda_in,
    input  logic       tx_empty,
    output logic       rx_enable,
    output logic       byte_received,
    output logic       load_data,
    output logic       read_enable,
    output logic       tx_enable,
    output logic [1:0] sda_mode,
    output logic       tx_underrun,
    output logic       busy
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [3:0] {
        IDLE, RX_ADDR, CHECK, WAIT_ACK, ACK, WAIT_NACK, NACK,
        LOAD, TX_BITS, TX_END, MACK, WAIT_STOP
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] bit_cnt;
    logic          clr_cnt, inc_cnt, sample_ack, ack_flag;
    logic          fall_only;

    // All inputs are single-cycle strobes with no back-pressure; a strobe is
    // consumed only by a state that uses it and otherwise dropped.
    assign fall_only = scl_fall & ~scl_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            ack_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (clr_cnt)
                bit_cnt <= '0;
            else if (inc_cnt)
                bit_cnt <= bit_cnt + 1'b1;
            if (sample_ack)
                ack_flag <= sda_in;
        end
    end

    always_comb begin
        next_state = state;
        clr_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        sample_ack = 1'b0;
        // STOP beats a repeated START when both land in the same cycle.
        if (state != IDLE && stop_found) begin
            next_state = IDLE;
        end else if (state != IDLE && start_found) begin
            next_state = RX_ADDR;
            clr_cnt    = 1'b1;
        end else begin
            case (state)
                IDLE: if (start_found) begin
                    next_state = RX_ADDR;
                    clr_cnt    = 1'b1;
                end
                RX_ADDR: if (scl_rise) begin
                    inc_cnt = 1'b1;
                    if (bit_cnt == LAST_BIT) next_state = CHECK;
                end
                CHECK:     next_state = (address_match && rw_mode) ? WAIT_ACK : WAIT_NACK;
                WAIT_ACK:  if (fall_only) next_state = ACK;
                ACK: if (fall_only) begin
                    next_state = LOAD;
                    clr_cnt    = 1'b1;
                end
                WAIT_NACK: if (fall_only) next_state = NACK;
                NACK:      if (fall_only) next_state = WAIT_STOP;
                LOAD:      next_state = TX_BITS;
                TX_BITS: if (scl_rise) begin
                    inc_cnt = 1'b1;
                    if (bit_cnt == LAST_BIT) next_state = TX_END;
                end
                TX_END:    if (fall_only) next_state = MACK;
                MACK: begin
                    if (scl_rise) begin
                        sample_ack = 1'b1;
                    end else if (scl_fall) begin
                        if (ack_flag) begin
                            next_state = WAIT_STOP;
                        end else begin
                            next_state = LOAD;
                            clr_cnt    = 1'b1;
                        end
                    end
                end
                WAIT_STOP: next_state = WAIT_STOP;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_enable     = 1'b0;
        byte_received = 1'b0;
        load_data     = 1'b0;
        read_enable   = 1'b0;
        tx_enable     = 1'b0;
        sda_mode      = 2'b00;
        tx_underrun   = 1'b0;
        busy          = (state != IDLE);
        case (state)
            RX_ADDR: rx_enable     = 1'b1;
            CHECK:   byte_received = 1'b1;
            ACK:     sda_mode      = 2'b01;
            NACK:    sda_mode      = 2'b10;
            LOAD: begin
                // On an empty FIFO the shift register still loads (stale data).
                load_data   = 1'b1;
                sda_mode    = 2'b11;
                read_enable = ~tx_empty;
                tx_underrun = tx_empty;
            end
            TX_BITS: begin
                sda_mode  = 2'b11;
                tx_enable = 1'b1;
            end
            TX_END:  sda_mode = 2'b11;
            default: sda_mode = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: drives bus-level transactions and checks SDA mode
// per SCL phase and pulse counts against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

    localparam int DATA_BITS = 8;
    localparam logic [6:0] SLAVE_ADDR = 7'h78;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_found = 1'b0, stop_found = 1'b0;
    logic       address_match = 1'b0, rw_mode = 1'b0;
    logic       scl_rise = 1'b0, scl_fall = 1'b0;
    logic       sda_in = 1'b1, tx_empty = 1'b1;
    logic       rx_enable, byte_received, load_data, read_enable, tx_enable;
    logic [1:0] sda_mode;
    logic       tx_underrun, busy;

    i2c_slave_ctrl #(.DATA_BITS(DATA_BITS)) dut (
        .clk(clk), .rst(rst), .start_found(start_found), .stop_found(stop_found),
        .address_match(address_match), .rw_mode(rw_mode), .scl_rise(scl_rise),
        .scl_fall(scl_fall), .sda_in(sda_in), .tx_empty(tx_empty),
        .rx_enable(rx_enable), .byte_received(byte_received), .load_data(load_data),
        .read_enable(read_enable), .tx_enable(tx_enable), .sda_mode(sda_mode),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_load, n_read, n_under, n_byte;
    logic [7:0] fifo_q[$];
    logic [1:0] exp_q[$];
    logic       sda_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: sample outputs on the falling edge, model the FIFO.
    task automatic tick();
        @(negedge clk);
        if (load_data)     n_load++;
        if (tx_underrun)   n_under++;
        if (byte_received) n_byte++;
        if (read_enable) begin
            n_read++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        tx_empty = (fifo_q.size() == 0);
    endtask

    task automatic clear_counts();
        n_load = 0; n_read = 0; n_under = 0; n_byte = 0;
    endtask

    task automatic fill_fifo(input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
        tx_empty = (fifo_q.size() == 0);
    endtask

    function automatic logic addr_acked(input logic [7:0] addr);
        return (addr[7:1] == SLAVE_ADDR) && addr[0];
    endfunction

    // Reference model: expected SDA mode in the low and high half of every SCL
    // clock of a transaction, plus the master's SDA level for that clock.
    task automatic build_plan(input logic [7:0] addr, input int nbytes);
        logic [1:0] m9;
        exp_q.delete();
        sda_q.delete();
        for (int i = 0; i < DATA_BITS; i++) begin
            exp_q.push_back(2'b00); exp_q.push_back(2'b00); sda_q.push_back(addr[7-i]);
        end
        m9 = addr_acked(addr) ? 2'b01 : 2'b10;
        exp_q.push_back(m9); exp_q.push_back(m9); sda_q.push_back(1'b1);
        if (addr_acked(addr)) begin
            for (int b = 0; b < nbytes; b++) begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    exp_q.push_back(2'b11); exp_q.push_back(2'b11); sda_q.push_back(1'b1);
                end
                exp_q.push_back(2'b00); exp_q.push_back(2'b00);
                sda_q.push_back(b == nbytes - 1);
            end
        end
        exp_q.push_back(2'b00); exp_q.push_back(2'b00); sda_q.push_back(1'b1);
    endtask

    // Driver: START, up to 'limit' SCL clocks of the plan (-1 = all), optional STOP.
    task automatic run_transaction(input logic [7:0] addr, input int nbytes,
                                   input int limit, input bit send_stop);
        int nclk;
        logic [1:0] m;
        build_plan(addr, nbytes);
        address_match = (addr[7:1] == SLAVE_ADDR);
        rw_mode = addr[0];
        start_found = 1'b1; tick(); start_found = 1'b0;
        checks++;
        if (busy !== 1'b1 || rx_enable !== 1'b1) begin
            errors++;
            $display("FAIL start_entry: busy=%0b rx_enable=%0b required 1 1", busy, rx_enable);
        end
        repeat (2) tick();
        nclk = sda_q.size();
        if (limit >= 0 && limit < nclk) nclk = limit;
        for (int c = 0; c < nclk; c++) begin
            sda_in = sda_q[c];
            scl_fall = 1'b1; tick(); scl_fall = 1'b0;
            repeat ($urandom_range(2, 4)) tick();
            m = exp_q.pop_front();
            checks++;
            if (sda_mode !== m) begin
                errors++;
                $display("FAIL sda_mode_low addr=%h clk=%0d: got %b required %b", addr, c + 1, sda_mode, m);
            end
            scl_rise = 1'b1; tick(); scl_rise = 1'b0;
            repeat ($urandom_range(2, 4)) tick();
            m = exp_q.pop_front();
            checks++;
            if (sda_mode !== m) begin
                errors++;
                $display("FAIL sda_mode_high addr=%h clk=%0d: got %b required %b", addr, c + 1, sda_mode, m);
            end
        end
        sda_in = 1'b1;
        if (send_stop) begin
            stop_found = 1'b1; tick(); stop_found = 1'b0;
            checks++;
            if (busy !== 1'b0 || sda_mode !== 2'b00) begin
                errors++;
                $display("FAIL stop_idle: busy=%0b sda_mode=%b required 0 00", busy, sda_mode);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({rx_enable, byte_received, load_data, read_enable, tx_enable, sda_mode, tx_underrun, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {rx_enable, byte_received, load_data, read_enable, tx_enable, sda_mode, tx_underrun, busy});
        end
        rst = 1'b0;
        tick();
        // Abort in the middle of the first data byte.
        fill_fifo(2);
        run_transaction(8'hF1, 2, 11, 1'b0);
        checks++;
        if (tx_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_tx_setup: tx_enable=%0b required 1", tx_enable);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({rx_enable, byte_received, load_data, read_enable, tx_enable, sda_mode, tx_underrun, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_tx: got %b required 000000000",
                     {rx_enable, byte_received, load_data, read_enable, tx_enable, sda_mode, tx_underrun, busy});
        end
        rst = 1'b0;
        tick();
        scl_fall = 1'b1; tick(); scl_fall = 1'b0; tick();
        scl_rise = 1'b1; tick(); scl_rise = 1'b0; tick();
        checks++;
        if (busy !== 1'b0 || sda_mode !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_after: busy=%0b sda_mode=%b required 0 00", busy, sda_mode);
        end
        fill_fifo(0);
    endtask

    task automatic test_read();
        fifo_q.delete();
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        tx_empty = 1'b0;
        clear_counts();
        run_transaction(8'hF1, 2, -1, 1'b1);
        checks++;
        if (n_load !== 2 || n_read !== 2 || n_under !== 0 || n_byte !== 1 || fifo_q.size() !== 0) begin
            errors++;
            $display("FAIL read_counts: load=%0d read=%0d under=%0d byte=%0d left=%0d required 2 2 0 1 0",
                     n_load, n_read, n_under, n_byte, fifo_q.size());
        end
    endtask

    task automatic test_addr_nomatch();
        fill_fifo(1);
        clear_counts();
        run_transaction(8'hA1, 1, -1, 1'b1);
        checks++;
        if (n_load !== 0 || n_read !== 0 || n_byte !== 1 || fifo_q.size() !== 1) begin
            errors++;
            $display("FAIL nomatch_counts: load=%0d read=%0d byte=%0d left=%0d required 0 0 1 1",
                     n_load, n_read, n_byte, fifo_q.size());
        end
        fill_fifo(0);
    endtask

    task automatic test_repeated_start();
        fill_fifo(1);
        clear_counts();
        run_transaction(8'hF0, 1, -1, 1'b0);
        checks++;
        if (busy !== 1'b1 || n_load !== 0 || n_byte !== 1) begin
            errors++;
            $display("FAIL write_nack: busy=%0b load=%0d byte=%0d required 1 0 1", busy, n_load, n_byte);
        end
        clear_counts();
        run_transaction(8'hF1, 1, -1, 1'b1);
        checks++;
        if (n_load !== 1 || n_read !== 1 || n_byte !== 1 || fifo_q.size() !== 0) begin
            errors++;
            $display("FAIL rstart_counts: load=%0d read=%0d byte=%0d left=%0d required 1 1 1 0",
                     n_load, n_read, n_byte, fifo_q.size());
        end
    endtask

    task automatic test_stop_mid_tx();
        fill_fifo(2);
        clear_counts();
        run_transaction(8'hF1, 2, DATA_BITS + 1 + 4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            scl_fall = 1'b1; tick(); scl_fall = 1'b0; tick();
            scl_rise = 1'b1; tick(); scl_rise = 1'b0; tick();
        end
        checks++;
        if (n_load !== 1 || n_read !== 1 || busy !== 1'b0 || fifo_q.size() !== 1) begin
            errors++;
            $display("FAIL stop_mid_tx: load=%0d read=%0d busy=%0b left=%0d required 1 1 0 1",
                     n_load, n_read, busy, fifo_q.size());
        end
        fill_fifo(0);
    endtask

    task automatic test_underrun();
        fill_fifo(0);
        clear_counts();
        run_transaction(8'hF1, 1, -1, 1'b1);
        checks++;
        if (n_under !== 1 || n_read !== 0 || n_load !== 1) begin
            errors++;
            $display("FAIL underrun: under=%0d read=%0d load=%0d required 1 0 1", n_under, n_read, n_load);
        end
        fill_fifo(1);
        clear_counts();
        run_transaction(8'hF1, 2, -1, 1'b1);
        checks++;
        if (n_under !== 1 || n_read !== 1 || n_load !== 2) begin
            errors++;
            $display("FAIL partial_underrun: under=%0d read=%0d load=%0d required 1 1 2", n_under, n_read, n_load);
        end
        fill_fifo(0);
    endtask

    task automatic test_random();
        logic [7:0] addr;
        int nbytes, fill, e_load, e_read;
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 4))
                0, 1:    addr = 8'hF1;
                2:       addr = 8'hF0;
                3:       addr = 8'hA1;
                default: addr = 8'($urandom_range(0, 255));
            endcase
            nbytes = $urandom_range(1, 3);
            fill   = $urandom_range(0, 3);
            fill_fifo(fill);
            clear_counts();
            run_transaction(addr, nbytes, -1, 1'b1);
            e_load = addr_acked(addr) ? nbytes : 0;
            e_read = (e_load < fill) ? e_load : fill;
            checks++;
            if (n_load !== e_load || n_read !== e_read || n_under !== e_load - e_read ||
                n_byte !== 1 || fifo_q.size() !== fill - e_read) begin
                errors++;
                $display("FAIL random_%0d addr=%h: load=%0d read=%0d under=%0d byte=%0d required %0d %0d %0d 1",
                         it, addr, n_load, n_read, n_under, n_byte, e_load, e_read, e_load - e_read);
            end
        end
        fill_fifo(0);
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_read();
        test_addr_nomatch();
        test_repeated_start();
        test_stop_mid_tx();
        test_underrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Transaction sequencer for the I2C slave.
- Consumes strobes from the start/stop/address decoder and from the SCL edge detector.
- Drives the RX shift-register enable, the TX load/shift and TX FIFO pop, and selects the SDA output mode.
- Supports read-only transactions: it ACKs its address only with R/W=1, then streams bytes until the master NACKs or a STOP is seen.

Parameters:
- DATA_BITS, 8, bits per byte on the bus (address byte and data bytes).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start_found  input  1  START condition strobe from decoder
- stop_found  input  1  STOP condition strobe from decoder
- address_match  input  1  received address byte matches slave address (valid in CHECK)
- rw_mode  input  1  R/W bit of received address byte (1 = read)
- scl_rise  input  1  one-cycle strobe, synchronized SCL rising edge
- scl_fall  input  1  one-cycle strobe, synchronized SCL falling edge
- sda_in  input  1  synchronized SDA level
- tx_empty  input  1  TX FIFO empty
- rx_enable  output  1  RX shift register samples SDA on scl_rise
- byte_received  output  1  one-cycle pulse, address byte complete
- load_data  output  1  one-cycle pulse, TX shift register parallel load
- read_enable  output  1  one-cycle pulse, TX FIFO pop
- tx_enable  output  1  TX shift register shifts on scl_fall
- sda_mode  output  2  00 release, 01 drive low (ACK), 10 drive high (NACK), 11 drive TX bit
- tx_underrun  output  1  one-cycle pulse, load attempted with FIFO empty
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state IDLE, bit counter 0.
  - All outputs 0; sda_mode=00.
  - Reset mid-transaction aborts immediately and releases SDA.
- Outputs are Moore-decoded from the registered state and change one cycle after the causing strobe.
- Bit counter (width clog2(DATA_BITS+1)):
  - cleared on entry to RX_ADDR and LOAD.
  - increments on scl_rise in RX_ADDR and TX_BITS.
- States and transitions:
  - IDLE: start_found -> RX_ADDR.
  - RX_ADDR: rx_enable=1. On the scl_rise that makes the count = DATA_BITS -> CHECK.
  - CHECK (1 cycle): byte_received=1. address_match && rw_mode -> WAIT_ACK; otherwise -> WAIT_NACK.
  - WAIT_ACK: sda_mode=00; scl_fall -> ACK.
  - ACK: sda_mode=01; scl_fall -> LOAD.
  - WAIT_NACK: sda_mode=00; scl_fall -> NACK.
  - NACK: sda_mode=10; scl_fall -> WAIT_STOP.
  - LOAD (1 cycle): load_data=1, sda_mode=11. If !tx_empty, read_enable=1; else tx_underrun=1 and the shift register loads stale data. -> TX_BITS.
  - TX_BITS: sda_mode=11, tx_enable=1. On the scl_rise that makes the count = DATA_BITS -> TX_END.
  - TX_END: sda_mode=11; scl_fall -> MACK. The last bit is held through its low edge.
  - MACK: sda_mode=00. On scl_rise, sample sda_in into an ack flag. On scl_fall: flag=0 -> LOAD; flag=1 -> WAIT_STOP.
  - WAIT_STOP: sda_mode=00; waits for stop_found/start_found.
- Global overrides, evaluated before per-state transitions, from any state except IDLE:
  - stop_found -> IDLE.
  - start_found -> RX_ADDR (repeated START).
  - If both strobes occur in the same cycle, stop_found wins.
- An scl_rise and an scl_fall never occur together. If they do, scl_rise is processed and scl_fall is ignored.
- Strobes arriving in states that do not use them are ignored.

Test Plan:
- Reset: hold rst=1 mid-TX_BITS -> next cycle sda_mode=00, busy=0, no pulses; after release, state IDLE.
- Read transaction, address 0xF1, FIFO holding 0xA5, 0x3C:
  - ACK slot shows sda_mode=01 for exactly one SCL low-high-low period.
  - Two load_data/read_enable pulses, with sda_mode=11 for 8 SCL clocks each.
  - Master ACKs after byte 1 and NACKs after byte 2.
  - STOP -> IDLE.
- Address 0xA1 (address_match=0): byte_received pulse, then sda_mode=10 during the 9th clock, no load_data; STOP -> IDLE.
- Address 0xF0 (match, rw_mode=0) -> NACK path as above; a repeated START in WAIT_STOP returns to RX_ADDR with the bit counter at 0.
- STOP after the 4th TX bit -> IDLE next cycle, sda_mode=00, no further read_enable.
- LOAD with tx_empty=1 -> tx_underrun one-cycle pulse, read_enable stays 0, TX_BITS entered normally.
